fb_line_fetch: RTL and testbench
================================

FB_LINE_FETCH -- requirements
Module: fb_line_fetch

Parameters
REQ-001 SHALL have parameter H_ACTIVE, default 800, meaning pixels per active line; must be a multiple of BURST_LEN.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter BURST_LEN, default 16, meaning 16-bit words per memory burst (power of two).
REQ-004 SHALL have parameter FB_BASE, default 0, meaning word address of pixel (0,0) in memory.

Interface
REQ-005 SHALL have port: clk  input  1  pixel clock, single clock domain.
REQ-006 SHALL have port: rst  input  1  reset; asynchronous, active-high.
REQ-007 SHALL have port: de  input  1  active-video enable from the timing generator.
REQ-008 SHALL have port: vsync  input  1  vertical sync from the timing generator, active-high.
REQ-009 SHALL have port: pixel_data  output  16  RGB565 pixel for the current active cycle.
REQ-010 SHALL have port: mem_req  output  1  burst read request.
REQ-011 SHALL have port: mem_addr  output  19  burst start word address.
REQ-012 SHALL have port: mem_ack  input  1  request accepted this cycle.
REQ-013 SHALL have port: mem_rvalid  input  1  read beat valid.
REQ-014 SHALL have port: mem_rdata  input  16  read beat data.
REQ-015 SHALL have port: underrun  output  1  one-cycle pulse: line started with unfilled buffer.

Function
REQ-016 SHALL hold two line buffers (buf0, buf1), each H_ACTIVE x 16 bits, with valid flags buf_valid[1:0].
REQ-017 SHALL register de and vsync each cycle (de_d, vsync_d); de falling edge = de_d & ~de; vsync rising edge = vsync & ~vsync_d.
REQ-018 SHALL drive pixel_data combinationally as buf[disp_sel][col] when de=1 and buf_valid[disp_sel]=1, else 0x0000.
REQ-019 SHALL increment col (10 bits) on every clock with de=1.
REQ-020 SHALL, on de falling edge: clear col to 0, clear buf_valid[disp_sel], toggle disp_sel.
REQ-021 SHALL pulse underrun for exactly one cycle at de rising edge (de & ~de_d) when buf_valid[disp_sel]=0.
REQ-022 SHALL, on vsync rising edge: clear col, set disp_sel=0, clear buf_valid to 00, and set next fetch line=0, next fetch buffer=buf0, next fetch address=FB_BASE.
REQ-023 SHALL implement fetch FSM states IDLE, REQ, DATA, DRAIN.
REQ-024 SHALL transition IDLE->REQ when fetch_line < V_ACTIVE and buf_valid[fetch_sel]=0.
REQ-025 SHALL, in REQ, assert mem_req with mem_addr stable until mem_ack=1, then go to DATA; mem_req deasserts the cycle after ack.
REQ-026 SHALL, in DATA, write each mem_rvalid beat to buf[fetch_sel][wr_col] and increment wr_col.
REQ-027 SHALL, after BURST_LEN beats, advance mem_addr by BURST_LEN and return to REQ if wr_col < H_ACTIVE.
REQ-028 SHALL, when wr_col reaches H_ACTIVE: set buf_valid[fetch_sel], clear wr_col, increment fetch_line, toggle fetch_sel, go IDLE.
REQ-029 SHALL compute addresses with an accumulator (line base += H_ACTIVE per line); no multiplier.
REQ-030 SHALL keep at most one burst outstanding.
REQ-031 SHALL, on a vsync rising edge while in REQ, complete the pending handshake and then go to DRAIN.
REQ-032 SHALL, on a vsync rising edge while in DATA, go to DRAIN.
REQ-033 SHALL, in DRAIN, discard the remaining beats of the current burst, then go IDLE with the line-0 state of REQ-022; no buffer write, no buf_valid set.
REQ-034 SHALL give a vsync rising edge coinciding with a de falling edge precedence (REQ-022 result).
REQ-035 SHALL give a fetch completion coinciding with a de falling edge that frees the other buffer both updates.
REQ-036 SHALL issue no fetch when fetch_line = V_ACTIVE, until the next vsync.

Reset
REQ-037 SHALL, while rst=1, asynchronously force: FSM=IDLE, mem_req=0, mem_addr=FB_BASE, underrun=0, buf_valid=00, disp_sel=0, fetch_sel=0, fetch_line=0, col=0, wr_col=0, de_d=0, vsync_d=0.
REQ-038 SHALL leave buffer contents undefined after reset; pixel_data=0 until a buffer is valid.
REQ-039 SHALL, on reset mid-burst, drop all further beats; the memory side is reset together.

Verification
REQ-040 SHALL verify reset then vsync pulse with zero-latency memory: bursts at 0,16,...,784 fill buf0, then 800..1584 fill buf1; buf_valid=11; no further mem_req.
REQ-041 SHALL verify memory data = address: first active line outputs pixel_data 0..799 on consecutive de cycles; second line outputs 800..1599; fetch of line 2 starts at address 1600 after the first de fall.
REQ-042 SHALL verify that stalling mem_ack for a full line time gives an underrun pulse at the next de rise and pixel_data=0 for that line.
REQ-043 SHALL verify that vsync asserted at beat 5 of a burst gives: remaining 11 beats discarded, next mem_addr=FB_BASE, buf_valid=00.
REQ-044 SHALL verify that holding mem_req until delayed ack (10 cycles) keeps mem_addr constant and yields exactly one request per burst.
REQ-045 SHALL verify that rst asserted mid-DATA drops mem_req and sets buf_valid=00 immediately (no clock edge needed).

Source files
------------

// File: rtl/fb_line_fetch.sv
// Ping-pong line buffers fed by single-outstanding memory bursts; pixel_data is combinational from the buffer on display.
// The fetch FSM holds mem_req/mem_addr until ack; vsync aborts a fetch, draining any accepted burst before restarting at line 0.
module fb_line_fetch #(
    parameter int H_ACTIVE  = 800,
    parameter int V_ACTIVE  = 480,
    parameter int BURST_LEN = 16,
    parameter int FB_BASE   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de,
    input  logic        vsync,
    output logic [15:0] pixel_data,
    output logic        mem_req,
    output logic [18:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic        underrun
);
    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam int AW = $clog2(H_ACTIVE);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;

    state_t          state;
    logic [15:0]     buf0 [H_ACTIVE];
    logic [15:0]     buf1 [H_ACTIVE];
    logic [1:0]      buf_valid;
    logic [1:0]      bv_next;
    logic            disp_sel;
    logic            fetch_sel;
    logic [9:0]      col;
    logic [CW-1:0]   wr_col;
    logic [BW-1:0]   beat_cnt;
    logic [LW-1:0]   fetch_line;
    logic [18:0]     line_base;
    logic            abort;
    logic            de_d;
    logic            vsync_d;

    logic de_fall, de_rise, vs_rise, beat_last, line_done, wr_en;

    assign de_fall   = de_d & ~de;
    assign de_rise   = de & ~de_d;
    assign vs_rise   = vsync & ~vsync_d;
    assign beat_last = mem_rvalid && (beat_cnt == BW'(BURST_LEN - 1));
    assign line_done = (state == DATA) && !vs_rise && beat_last && (wr_col == CW'(H_ACTIVE - 1));
    assign wr_en     = (state == DATA) && mem_rvalid && !vs_rise;

    always_comb begin
        pixel_data = 16'h0000;
        if (de && buf_valid[disp_sel])
            pixel_data = disp_sel ? buf1[col[AW-1:0]] : buf0[col[AW-1:0]];
    end

    // vsync wins over everything; otherwise a de fall and a fetch completion both land.
    always_comb begin
        bv_next = buf_valid;
        if (de_fall)
            bv_next[disp_sel] = 1'b0;
        if (line_done)
            bv_next[fetch_sel] = 1'b1;
        if (vs_rise)
            bv_next = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (fetch_sel)
                buf1[wr_col[AW-1:0]] <= mem_rdata;
            else
                buf0[wr_col[AW-1:0]] <= mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= 19'(FB_BASE);
            line_base  <= 19'(FB_BASE);
            underrun   <= 1'b0;
            buf_valid  <= 2'b00;
            disp_sel   <= 1'b0;
            fetch_sel  <= 1'b0;
            fetch_line <= '0;
            col        <= '0;
            wr_col     <= '0;
            beat_cnt   <= '0;
            abort      <= 1'b0;
            de_d       <= 1'b0;
            vsync_d    <= 1'b0;
        end else begin
            de_d      <= de;
            vsync_d   <= vsync;
            underrun  <= de_rise & ~buf_valid[disp_sel];
            buf_valid <= bv_next;

            if (vs_rise) begin
                col      <= '0;
                disp_sel <= 1'b0;
            end else if (de_fall) begin
                col      <= '0;
                disp_sel <= ~disp_sel;
            end else if (de) begin
                col <= col + 10'd1;
            end

            if (vs_rise) begin
                fetch_line <= '0;
                fetch_sel  <= 1'b0;
                line_base  <= 19'(FB_BASE);
                wr_col     <= '0;
            end

            case (state)
                IDLE: begin
                    if (vs_rise) begin
                        mem_addr <= 19'(FB_BASE);
                    end else if (fetch_line < LW'(V_ACTIVE) && !buf_valid[fetch_sel]) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                REQ: begin
                    // The address stays put until the handshake, even across a vsync.
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        beat_cnt <= '0;
                        if (vs_rise || abort) begin
                            state    <= DRAIN;
                            abort    <= 1'b0;
                            mem_addr <= 19'(FB_BASE);
                        end else begin
                            state <= DATA;
                        end
                    end else if (vs_rise) begin
                        abort <= 1'b1;
                    end
                end
                DATA: begin
                    if (mem_rvalid) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        if (vs_rise) begin
                            mem_addr <= 19'(FB_BASE);
                            state    <= beat_last ? IDLE : DRAIN;
                        end else if (line_done) begin
                            wr_col     <= '0;
                            fetch_line <= fetch_line + LW'(1);
                            fetch_sel  <= ~fetch_sel;
                            line_base  <= line_base + 19'(H_ACTIVE);
                            mem_addr   <= line_base + 19'(H_ACTIVE);
                            state      <= IDLE;
                        end else if (beat_last) begin
                            wr_col   <= wr_col + CW'(1);
                            mem_addr <= mem_addr + 19'(BURST_LEN);
                            mem_req  <= 1'b1;
                            state    <= REQ;
                        end else begin
                            wr_col <= wr_col + CW'(1);
                        end
                    end else if (vs_rise) begin
                        mem_addr <= 19'(FB_BASE);
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_rvalid) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        if (beat_last)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_line_fetch.sv
// Directed bench for fb_line_fetch with a behavioural burst memory returning data = address.
`timescale 1ns/1ps
module tb_fb_line_fetch;
    localparam int H  = 800;
    localparam int BL = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        de = 1'b0;
    logic        vsync = 1'b0;
    logic [15:0] pixel_data;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        underrun;

    int tests = 0;
    int fails = 0;

    bit stall = 1'b0;
    bit ack_ok = 1'b1;
    int ack_delay = 0;
    int req_wait = 0;
    int pend = 0;
    int beat_addr = 0;
    int cyc = 0;
    int hs_addr[$];
    int hs_cyc[$];
    int req_rise = 0;
    int addr_glitch = 0;
    bit req_prev = 1'b0;
    bit pend_req = 1'b0;
    int wait_addr = 0;

    assign mem_ack = mem_req & ack_ok;
    always #5 clk = ~clk;

    fb_line_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .de         (de),
        .vsync      (vsync),
        .pixel_data (pixel_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .underrun   (underrun)
    );

    // Memory: samples the handshake at the edge, streams BL beats starting the next cycle.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pend = 0; req_wait = 0; pend_req = 1'b0; req_prev = 1'b0;
        end else begin
            if (mem_req && !req_prev) req_rise++;
            if (mem_req && pend_req && int'(mem_addr) != wait_addr) addr_glitch++;
            pend_req  = mem_req && !mem_ack;
            wait_addr = int'(mem_addr);
            req_prev  = mem_req;
            if (mem_req && mem_ack) begin
                hs_addr.push_back(int'(mem_addr));
                hs_cyc.push_back(cyc);
                beat_addr = int'(mem_addr);
                pend = BL;
                req_wait = 0;
            end else if (mem_req) begin
                req_wait++;
            end
        end
        #1;
        if (pend > 0 && !rst) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'(beat_addr);
            beat_addr++;
            pend--;
        end else begin
            mem_rvalid = 1'b0;
        end
        ack_ok = !stall && (req_wait >= ack_delay);
    end

    task automatic pulse_vsync;
        @(posedge clk); #1 vsync = 1'b1;
        @(posedge clk); #1 vsync = 1'b0;
    endtask

    task automatic wait_bv(input logic [1:0] mask, input logic [1:0] want, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if ((dut.buf_valid & mask) === want) ok = 1'b1;
        end
    endtask

    task automatic wait_hs(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (hs_addr.size() > n) ok = 1'b1;
        end
    endtask

    task automatic run_line(input int base, input bit blank, output int errs, output int unds);
        logic [15:0] exp;
        errs = 0; unds = 0;
        for (int i = 0; i < H; i++) begin
            @(posedge clk); #1 de = 1'b1;
            @(negedge clk);
            exp = blank ? 16'h0000 : 16'(base + i);
            if (pixel_data !== exp) errs++;
            if (underrun) unds++;
        end
        @(posedge clk); #1 de = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (underrun) unds++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1 rst = 1'b1;
        de = 1'b1;
        @(negedge clk);
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
        tests++; if (mem_addr !== 19'd0) begin fails++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %0b want 0", underrun); end
        tests++; if (pixel_data !== 16'h0000) begin fails++; $display("FAIL reset_pixel: got %h want 0000", pixel_data); end
        tests++; if (dut.buf_valid !== 2'b00) begin fails++; $display("FAIL reset_buf_valid: got %b want 00", dut.buf_valid); end
        de = 1'b0;
    endtask

    task automatic test_fill;
        bit ok;
        int errs;
        vsync = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        hs_addr.delete(); hs_cyc.delete();
        @(posedge clk); #1 vsync = 1'b0;
        wait_bv(2'b11, 2'b11, 4000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL fill_timeout: buf_valid %b want 11", dut.buf_valid); end
        tests++; if (hs_addr.size() != 100) begin fails++; $display("FAIL fill_burst_count: got %0d want 100", hs_addr.size()); end
        errs = 0;
        for (int i = 0; i < hs_addr.size() && i < 100; i++)
            if (hs_addr[i] != i * BL) errs++;
        tests++; if (errs != 0) begin fails++; $display("FAIL fill_addr_seq: %0d bad addresses want 0", errs); end
        repeat (50) @(negedge clk);
        tests++; if (hs_addr.size() != 100 || mem_req !== 1'b0) begin
            fails++; $display("FAIL fill_quiet: bursts %0d req %0b want 100 and 0", hs_addr.size(), mem_req);
        end
    endtask

    task automatic test_display;
        int e, u, n0;
        bit ok;
        n0 = hs_addr.size();
        run_line(0, 1'b0, e, u);
        tests++; if (e != 0) begin fails++; $display("FAIL line0_pixels: %0d wrong want 0", e); end
        tests++; if (u != 0) begin fails++; $display("FAIL line0_underrun: %0d pulses want 0", u); end
        wait_hs(n0, 50, ok);
        tests++; if (!ok || hs_addr[n0] != 1600) begin
            fails++; $display("FAIL line2_fetch_addr: got %0d want 1600", ok ? hs_addr[n0] : -1);
        end
        run_line(800, 1'b0, e, u);
        tests++; if (e != 0 || u != 0) begin fails++; $display("FAIL line1_pixels: %0d wrong %0d underruns want 0 0", e, u); end
        wait_bv(2'b01, 2'b01, 3000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL line2_fill_timeout: buf_valid %b want x1", dut.buf_valid); end
        run_line(1600, 1'b0, e, u);
        tests++; if (e != 0 || u != 0) begin fails++; $display("FAIL line2_pixels: %0d wrong %0d underruns want 0 0", e, u); end
    endtask

    task automatic test_underrun;
        int e, u;
        bit ok;
        wait_bv(2'b11, 2'b11, 4000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL underrun_setup: buf_valid %b want 11", dut.buf_valid); end
        stall = 1'b1;
        @(negedge clk);
        pulse_vsync();
        repeat (40) @(negedge clk);
        run_line(0, 1'b1, e, u);
        tests++; if (e != 0) begin fails++; $display("FAIL underrun_pixels: %0d nonzero want 0", e); end
        tests++; if (u != 1) begin fails++; $display("FAIL underrun_pulse: got %0d pulses want 1", u); end
        stall = 1'b0;
    endtask

    task automatic test_vsync_abort;
        int n0, h;
        bit ok;
        wait_bv(2'b11, 2'b11, 4000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL abort_setup: buf_valid %b want 11", dut.buf_valid); end
        stall = 1'b1;
        @(negedge clk);
        pulse_vsync();
        repeat (5) @(negedge clk);
        n0 = hs_addr.size();
        stall = 1'b0;
        wait_hs(n0, 20, ok);
        tests++; if (!ok) begin fails++; $display("FAIL abort_first_ack: no handshake want 1"); end
        h = ok ? hs_cyc[n0] : cyc;
        repeat (5) @(posedge clk);
        #1 vsync = 1'b1;
        @(posedge clk); #1 vsync = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (dut.buf_valid !== 2'b00 || mem_req !== 1'b0) begin
            fails++; $display("FAIL abort_drain_state: buf_valid %b req %0b want 00 0", dut.buf_valid, mem_req);
        end
        wait_hs(n0 + 1, 40, ok);
        tests++; if (!ok || hs_addr[n0 + 1] != 0) begin
            fails++; $display("FAIL abort_next_addr: got %0d want 0", ok ? hs_addr[n0 + 1] : -1);
        end
        tests++; if (!ok || hs_cyc[n0 + 1] <= h + 16) begin
            fails++; $display("FAIL abort_drain_len: next req at +%0d want >16", ok ? hs_cyc[n0 + 1] - h : -1);
        end
    endtask

    task automatic test_delayed_ack;
        int n0;
        bit ok;
        wait_bv(2'b11, 2'b11, 4000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL delay_setup: buf_valid %b want 11", dut.buf_valid); end
        ack_delay = 10;
        n0 = hs_addr.size();
        req_rise = 0;
        addr_glitch = 0;
        pulse_vsync();
        wait_bv(2'b11, 2'b11, 8000, ok);
        repeat (20) @(negedge clk);
        tests++; if (!ok || req_rise != 100) begin fails++; $display("FAIL delay_req_count: got %0d want 100", req_rise); end
        tests++; if (hs_addr.size() - n0 != 100) begin fails++; $display("FAIL delay_ack_count: got %0d want 100", hs_addr.size() - n0); end
        tests++; if (addr_glitch != 0) begin fails++; $display("FAIL delay_addr_stable: %0d changes want 0", addr_glitch); end
        tests++; if (hs_addr[hs_addr.size() - 1] != 1584) begin
            fails++; $display("FAIL delay_last_addr: got %0d want 1584", hs_addr[hs_addr.size() - 1]);
        end
        ack_delay = 0;
    endtask

    task automatic test_reset_mid;
        bit ok;
        ok = 1'b0;
        pulse_vsync();
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (dut.buf_valid === 2'b01 && mem_rvalid) ok = 1'b1;
        end
        tests++; if (!ok) begin fails++; $display("FAIL rstmid_setup: buf_valid %b want 01 in burst", dut.buf_valid); end
        #2 rst = 1'b1;
        #1;
        tests++; if (dut.buf_valid !== 2'b00) begin fails++; $display("FAIL rstmid_buf_valid: got %b want 00", dut.buf_valid); end
        tests++; if (mem_req !== 1'b0 || mem_addr !== 19'd0) begin
            fails++; $display("FAIL rstmid_mem: req %0b addr %0d want 0 0", mem_req, mem_addr);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_display();
        test_underrun();
        test_vsync_abort();
        test_delayed_ack();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
